// File: rtl/amer_put_pkg.sv
// Shared types and constants for the American-put pricing core and its run sequencer.
// The default cycle constants are also used by the core's address generator (N=4000).
package amer_put_pkg;

  localparam int DOUBLE_W = 64;

  localparam int unsigned S1_CYCLES_DEF = 32'd8192;
  localparam int unsigned S2_CYCLES_DEF = 32'd8004002;
  localparam int unsigned RD_LAT_DEF    = 32'd3;
  localparam int          CNT_W_DEF     = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_READ = 3'd3,
    ST_HOLD = 3'd4
  } seq_state_t;

endpackage

// File: rtl/amer_put_phase_cnt.sv
// Loadable down-counter shared by all three run phases. It stops at zero
// instead of wrapping, and expiry is signalled by a compare-to-zero flag.
module amer_put_phase_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_fast,
  input  logic             nrst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority over decrement; decrement is ignored once at zero.
  always_ff @(posedge clk_fast or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/amer_put_seq.sv
// Run sequencer around the American-put pricing core: accepts one job,
// holds its parameters on the core inputs, times start_s1/start_s2 and the
// result readout, and hands the captured price back to the host.
// Optional feature: define AMER_PUT_SEQ_STATUS_EN to add the run_cycles port.
//
// state | meaning
// IDLE  | waiting for a job, req_ready high
// S1    | stage 1 running (table fill / membank init)
// S2    | stage 2 running (backward induction)
// READ  | readout window, waiting for result_in to settle
// HOLD  | price on res_data, res_valid high until res_ready
module amer_put_seq
  import amer_put_pkg::*;
#(
  parameter int unsigned S1_CYCLES = S1_CYCLES_DEF,
  parameter int unsigned S2_CYCLES = S2_CYCLES_DEF,
  parameter int unsigned RD_LAT    = RD_LAT_DEF,
  parameter int          CNT_W     = CNT_W_DEF
) (
  input  logic                clk_fast,
  input  logic                nrst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DOUBLE_W-1:0] req_p_up,
  input  logic [DOUBLE_W-1:0] req_p_down,
  input  logic [DOUBLE_W-1:0] req_log_lambda_up,
  input  logic [DOUBLE_W-1:0] req_log_lambda_down,
  input  logic [DOUBLE_W-1:0] req_K_over_S,
  output logic [DOUBLE_W-1:0] p_up,
  output logic [DOUBLE_W-1:0] p_down,
  output logic [DOUBLE_W-1:0] log_lambda_up,
  output logic [DOUBLE_W-1:0] log_lambda_down,
  output logic [DOUBLE_W-1:0] K_over_S,
  output logic                start_s1,
  output logic                start_s2,
  input  logic [DOUBLE_W-1:0] result_in,
  input  logic                abort,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DOUBLE_W-1:0] res_data,
  output logic                busy
`ifdef AMER_PUT_SEQ_STATUS_EN
  ,output logic [CNT_W-1:0]   run_cycles
`endif
);

  seq_state_t       state, state_nxt;
  logic             accept, s1_nxt, s2_nxt, cap;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  amer_put_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk_fast (clk_fast),
    .nrst     (nrst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, counter control and next values of the registered pulses.
  // The READ phase is loaded with RD_LAT (not RD_LAT-1) so that result_in is
  // sampled at the end of the cycle in which it first becomes valid.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    s1_nxt    = 1'b0;
    s2_nxt    = 1'b0;
    cap       = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          s1_nxt    = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(S1_CYCLES - 32'd1);
          state_nxt = ST_S1;
        end
      end
      ST_S1: begin
        if (cnt_zero) begin
          s2_nxt    = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(S2_CYCLES - 32'd1);
          state_nxt = ST_S2;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_S2: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(RD_LAT);
          state_nxt = ST_READ;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_zero) begin
          cap       = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over every transition and swallows any pulse or capture due now.
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      s2_nxt    = 1'b0;
      cap       = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
    end
  end

  // State register and registered handshake/pulse outputs.
  always_ff @(posedge clk_fast or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      start_s1  <= s1_nxt;
      start_s2  <= s2_nxt;
      res_valid <= (state_nxt == ST_HOLD);
      if (cap) begin
        res_data <= result_in;
      end
    end
  end

  // Job parameters stay on the core inputs until the next accepted job.
  always_ff @(posedge clk_fast or negedge nrst) begin
    if (!nrst) begin
      p_up            <= '0;
      p_down          <= '0;
      log_lambda_up   <= '0;
      log_lambda_down <= '0;
      K_over_S        <= '0;
    end else if (accept) begin
      p_up            <= req_p_up;
      p_down          <= req_p_down;
      log_lambda_up   <= req_log_lambda_up;
      log_lambda_down <= req_log_lambda_down;
      K_over_S        <= req_K_over_S;
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef AMER_PUT_SEQ_STATUS_EN
  // Run-length counter: restarts on acceptance, counts active phases, freezes in HOLD/IDLE.
  always_ff @(posedge clk_fast or negedge nrst) begin
    if (!nrst) begin
      run_cycles <= '0;
    end else if (accept) begin
      run_cycles <= '0;
    end else if (((state == ST_S1) || (state == ST_S2) || (state == ST_READ)) &&
                 (run_cycles != '1)) begin
      run_cycles <= run_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_amer_put_seq.sv
// Self-checking bench for amer_put_seq with S1=3, S2=5, RD=2.
// The reference model works from job timestamps: outputs are derived from the
// number of edges since acceptance rather than from any state machine.
module tb_amer_put_seq;

  localparam int S1 = 3;
  localparam int S2 = 5;
  localparam int RD = 2;
  localparam int CW = 16;
  localparam int RES_OFS = 1 + S1 + S2 + RD;

  logic        clk_fast = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_p_up = '0, req_p_down = '0, req_log_lambda_up = '0;
  logic [63:0] req_log_lambda_down = '0, req_K_over_S = '0;
  logic [63:0] p_up, p_down, log_lambda_up, log_lambda_down, K_over_S;
  logic        start_s1, start_s2;
  logic [63:0] result_in = '0;
  logic        abort = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        busy;
`ifdef AMER_PUT_SEQ_STATUS_EN
  logic [CW-1:0] run_cycles;
`endif

  amer_put_seq #(.S1_CYCLES(S1), .S2_CYCLES(S2), .RD_LAT(RD), .CNT_W(CW)) dut (
    .clk_fast            (clk_fast),
    .nrst                (nrst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_p_up            (req_p_up),
    .req_p_down          (req_p_down),
    .req_log_lambda_up   (req_log_lambda_up),
    .req_log_lambda_down (req_log_lambda_down),
    .req_K_over_S        (req_K_over_S),
    .p_up                (p_up),
    .p_down              (p_down),
    .log_lambda_up       (log_lambda_up),
    .log_lambda_down     (log_lambda_down),
    .K_over_S            (K_over_S),
    .start_s1            (start_s1),
    .start_s2            (start_s2),
    .result_in           (result_in),
    .abort               (abort),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_data            (res_data),
    .busy                (busy)
`ifdef AMER_PUT_SEQ_STATUS_EN
    ,.run_cycles         (run_cycles)
`endif
  );

  always #5 clk_fast = ~clk_fast;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt = 0;

  always @(posedge clk_fast) ecnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic logic [63:0] res_pat(input int e);
    logic [31:0] lo;
    lo = e;
    return {lo ^ 32'hC0DE5A5A, lo};
  endfunction

  // Core result stand-in: a distinct value every cycle, tagged with the edge count.
  initial begin
    forever begin
      @(posedge clk_fast);
      #1;
      result_in = res_pat(ecnt);
    end
  end

  // ---------------- reference model ----------------
  bit          m_job = 0, m_hold = 0, m_ready = 0;
  bit          pre_job, pre_hold;
  int          m_e = 0, m_ta = 0, d;
  logic        x_s1 = 0, x_s2 = 0;
  logic [63:0] x_rd = '0;
  logic [63:0] x_par [5] = '{default: '0};
`ifdef AMER_PUT_SEQ_STATUS_EN
  logic [CW-1:0] x_rc = '0;
`endif

  always @(posedge clk_fast or negedge nrst) begin
    if (!nrst) begin
      m_job = 0; m_hold = 0; m_ready = 0;
      x_s1 = 0; x_s2 = 0; x_rd = '0;
      for (int k = 0; k < 5; k++) x_par[k] = '0;
`ifdef AMER_PUT_SEQ_STATUS_EN
      x_rc = '0;
`endif
    end else begin
      m_e++;
      pre_job = m_job;
      pre_hold = m_hold;
      x_s1 = 0;
      x_s2 = 0;
`ifdef AMER_PUT_SEQ_STATUS_EN
      if (pre_job && !pre_hold && x_rc != '1) x_rc = x_rc + 1'b1;
`endif
      if (!pre_job) begin
        if (m_ready && req_valid) begin
          m_job = 1; m_ta = m_e; x_s1 = 1;
          x_par[0] = req_p_up; x_par[1] = req_p_down;
          x_par[2] = req_log_lambda_up; x_par[3] = req_log_lambda_down;
          x_par[4] = req_K_over_S;
`ifdef AMER_PUT_SEQ_STATUS_EN
          x_rc = '0;
`endif
        end
      end else if (abort) begin
        m_job = 0; m_hold = 0;
      end else if (pre_hold) begin
        if (res_ready) begin
          m_job = 0; m_hold = 0;
        end
      end else begin
        d = m_e - m_ta;
        if (d == S1) x_s2 = 1;
        if (d == RES_OFS) begin
          m_hold = 1;
          x_rd = result_in;
        end
      end
      m_ready = !m_job;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk_fast) begin
    chk("req_ready", req_ready, m_ready);
    chk("busy", busy, m_job);
    chk("start_s1", start_s1, x_s1);
    chk("start_s2", start_s2, x_s2);
    chk("res_valid", res_valid, m_hold);
    chk("res_data", res_data, x_rd);
    chk("p_up", p_up, x_par[0]);
    chk("p_down", p_down, x_par[1]);
    chk("log_lambda_up", log_lambda_up, x_par[2]);
    chk("log_lambda_down", log_lambda_down, x_par[3]);
    chk("K_over_S", K_over_S, x_par[4]);
`ifdef AMER_PUT_SEQ_STATUS_EN
    chk("run_cycles", run_cycles, x_rc);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic rand_params();
    req_p_up = {$urandom, $urandom};
    req_p_down = {$urandom, $urandom};
    req_log_lambda_up = {$urandom, $urandom};
    req_log_lambda_down = {$urandom, $urandom};
    req_K_over_S = {$urandom, $urandom};
  endtask

  task automatic wait_s1(input string name, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (start_s1) begin
        at = ecnt;
        break;
      end
    end
    if (at < 0) chk(name, 64'd0, 64'd1);
  endtask

  task automatic wait_rv(input string name, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) begin
        at = ecnt;
        break;
      end
    end
    if (at < 0) chk(name, 64'd0, 64'd1);
  endtask

  int ta, hs, s, cnt_p;
  logic [63:0] held;

  initial begin
    repeat (3) tick();
    nrst = 1'b1;
    tick();
    chk("ready_after_reset", req_ready, 1'b1);

    // Nominal job with fixed parameters.
    req_p_up = 64'h3FE0000000000000;
    req_p_down = 64'h3FDF5C28F5C28F5C;
    req_log_lambda_up = 64'h3F9999999999999A;
    req_log_lambda_down = 64'hBF9999999999999A;
    req_K_over_S = 64'h3FF0000000000000;
    req_valid = 1'b1;
    tick();
    ta = ecnt;
    req_valid = 1'b0;
    chk("nom_s1_at_t1", start_s1, 1'b1);
    chk("nom_p_up", p_up, 64'h3FE0000000000000);
    chk("nom_k_over_s", K_over_S, 64'h3FF0000000000000);
    repeat (S1) tick();
    chk("nom_s2_at_t4", start_s2, 1'b1);
    repeat (RES_OFS - 1 - S1) tick();
    chk("nom_rv_before_t12", res_valid, 1'b0);
    tick();
    chk("nom_rv_at_t12", res_valid, 1'b1);
    held = res_pat(ta + 10);
    chk("nom_res_data", res_data, held);
`ifdef AMER_PUT_SEQ_STATUS_EN
    chk("nom_run_cycles", run_cycles, 16'd11);
`endif

    // Backpressure with a pending request.
    rand_params();
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_data", res_data, held);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    hs = ecnt - 1;
    chk("hs_ready_next", req_ready, 1'b1);
`ifdef AMER_PUT_SEQ_STATUS_EN
    chk("idle_run_cycles", run_cycles, 16'd11);
`endif
    tick();
    chk("b2b_gap_1", ecnt - hs, 64'd2);
    chk("b2b_s1_1", start_s1, 1'b1);

    // Back-to-back: req_valid stays high, res_ready stays high.
    wait_rv("b2b_rv_timeout", hs);
    wait_s1("b2b_s1_timeout", s);
    chk("b2b_gap_2", s - hs, 64'd2);
    req_valid = 1'b0;

    // Abort on the edge that would raise start_s2.
    repeat (S1 - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_no_s2", start_s2, 1'b0);
    chk("abort_idle", busy, 1'b0);
    cnt_p = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start_s2 || res_valid) cnt_p++;
    end
    chk("abort_no_result", cnt_p, 0);

    // New job after abort runs normally.
    rand_params();
    req_valid = 1'b1;
    tick();
    ta = ecnt;
    req_valid = 1'b0;
    wait_rv("post_abort_rv_timeout", s);
    chk("post_abort_latency", s - ta, 64'd11);

    // Reset in the middle of S2.
    rand_params();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    nrst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_p_up", p_up, 64'd0);
    repeat (3) tick();
    nrst = 1'b1;
    cnt_p = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start_s1 || start_s2 || res_valid) cnt_p++;
    end
    chk("rst_no_pulse", cnt_p, 0);
    chk("rst_ready", req_ready, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      if (req_valid) rand_params();
      res_ready = $urandom_range(0, 1);
      abort = ($urandom_range(0, 15) == 0);
      tick();
    end
    req_valid = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
    $fatal(1, "watchdog");
  end

endmodule
